mem_port_arbiter: RTL and testbench

- Shares the single-port synchronous memory (address / data_out / data_in / we) between two requesters: requester 0 is the core's memory interface and requester 1 is the program loader/DMA.
- Round-robin request/grant arbitration, one outstanding transaction at a time.
- Registers the memory-side signals and returns read data with a one-cycle valid pulse.
- Sits between the requesters and the memory model at top level.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the two requester ports and the memory-side
// port of mem_port_arbiter.
//   Requester side : req0/1, we0/1, addr0/1, wdata0/1 in; gnt0/1, rvalid0/1,
//                    rdata out.
//   Memory side    : mem_address, mem_data_out, mem_we out; mem_data_in in.
//   Status         : busy out.
// modport slave  - the arbiter itself.
// modport master - the environment (both requesters plus the memory model).
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_in,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_address, mem_data_out,
               mem_we, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_in,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_address, mem_data_out,
               mem_we, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// core (requester 0) and the loader/DMA (requester 1). Round-robin arbitration,
// one transaction in flight, registered memory-side signals, read data
// returned with a one-cycle rvalid pulse to the owner.
// Ports:
//   i_clk     - clock, rising edge.
//   i_resetn  - asynchronous active-low reset.
//   io_bus    - mem_port_arbiter_if.slave: requester handshakes, memory port,
//               busy flag.
// READ_LATENCY is the number of cycles from mem_address to valid mem_data_in,
// legal range 1..7 (held in a 3-bit wait counter).
module mem_port_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    mem_port_arbiter_if.slave io_bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY);

    logic [1:0]            r_state;
    logic                  r_prio;
    logic                  r_owner;
    logic                  r_op_we;
    logic [2:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_data_out;

    logic w_idle;
    logic w_gnt0;
    logic w_gnt1;

    // Gating with i_resetn keeps grants low while reset is held, even though
    // the state register already reads IDLE.
    assign w_idle = (r_state == ST_IDLE) && i_resetn;
    // On contention r_prio picks the winner: 0 -> requester 0, 1 -> requester 1.
    assign w_gnt0 = w_idle && io_bus.req0 && (!io_bus.req1 || !r_prio);
    assign w_gnt1 = w_idle && io_bus.req1 && (!io_bus.req0 || r_prio);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state        <= ST_IDLE;
            r_prio         <= 1'b0;
            r_owner        <= 1'b0;
            r_op_we        <= 1'b0;
            r_cnt          <= 3'd0;
            r_rdata        <= '0;
            r_mem_address  <= '0;
            r_mem_data_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_owner        <= w_gnt1;
                        // The loser of this round wins the next tie.
                        r_prio         <= !w_gnt1;
                        r_op_we        <= w_gnt1 ? io_bus.we1 : io_bus.we0;
                        r_mem_address  <= w_gnt1 ? io_bus.addr1 : io_bus.addr0;
                        r_mem_data_out <= w_gnt1 ? io_bus.wdata1 : io_bus.wdata0;
                        r_state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_op_we) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= LAT_LOAD;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    // Count of 1 marks the cycle in which memory data is valid.
                    if (r_cnt == 3'd1) begin
                        r_rdata <= io_bus.mem_data_in;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.gnt0         = w_gnt0;
    assign io_bus.gnt1         = w_gnt1;
    assign io_bus.rvalid0      = (r_state == ST_RESP) && !r_owner;
    assign io_bus.rvalid1      = (r_state == ST_RESP) && r_owner;
    // Decoded from state so an asynchronous reset drops the strobe at once.
    assign io_bus.mem_we       = (r_state == ST_ISSUE) && r_op_we;
    assign io_bus.busy         = (r_state != ST_IDLE);
    assign io_bus.rdata        = r_rdata;
    assign io_bus.mem_address  = r_mem_address;
    assign io_bus.mem_data_out = r_mem_data_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives two arbiters (READ_LATENCY 1 and 3) from one
// process and compares every output every cycle against a transaction-level
// model: a grant at cycle T opens a transaction of known length, and every
// output is a simple function of (cycle - T). Directed scenarios pin the model
// with literal values, then randomized traffic runs against the same model.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NDUT = 2;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    mem_port_arbiter #(.READ_LATENCY(LAT0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut_l1 (
        .i_clk    (clk),
        .i_resetn (resetn),
        .io_bus   (bus_a)
    );

    mem_port_arbiter #(.READ_LATENCY(LAT1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut_l3 (
        .i_clk    (clk),
        .i_resetn (resetn),
        .io_bus   (bus_b)
    );

    // Driven inputs (changed only at negedge) and pending requests (next cycle).
    logic [1:0]    d_req   [NDUT];
    logic [1:0]    d_we    [NDUT];
    logic [AW-1:0] d_addr  [NDUT][2];
    logic [DW-1:0] d_wdata [NDUT][2];
    logic [DW-1:0] d_mdin  [NDUT];
    logic [1:0]    s_pend  [NDUT];
    logic [1:0]    s_we    [NDUT];
    logic [AW-1:0] s_addr  [NDUT][2];
    logic [DW-1:0] s_wdata [NDUT][2];
    logic          mdin_en [NDUT];
    logic [DW-1:0] mdin_dir[NDUT];

    assign bus_a.req0 = d_req[0][0];       assign bus_a.req1 = d_req[0][1];
    assign bus_a.we0 = d_we[0][0];         assign bus_a.we1 = d_we[0][1];
    assign bus_a.addr0 = d_addr[0][0];     assign bus_a.addr1 = d_addr[0][1];
    assign bus_a.wdata0 = d_wdata[0][0];   assign bus_a.wdata1 = d_wdata[0][1];
    assign bus_a.mem_data_in = d_mdin[0];
    assign bus_b.req0 = d_req[1][0];       assign bus_b.req1 = d_req[1][1];
    assign bus_b.we0 = d_we[1][0];         assign bus_b.we1 = d_we[1][1];
    assign bus_b.addr0 = d_addr[1][0];     assign bus_b.addr1 = d_addr[1][1];
    assign bus_b.wdata0 = d_wdata[1][0];   assign bus_b.wdata1 = d_wdata[1][1];
    assign bus_b.mem_data_in = d_mdin[1];

    logic [1:0]    a_gnt    [NDUT];
    logic [1:0]    a_rvalid [NDUT];
    logic          a_busy   [NDUT];
    logic          a_we     [NDUT];
    logic [DW-1:0] a_rdata  [NDUT];
    logic [AW-1:0] a_addr   [NDUT];
    logic [DW-1:0] a_wdo    [NDUT];

    assign a_gnt[0] = {bus_a.gnt1, bus_a.gnt0};
    assign a_rvalid[0] = {bus_a.rvalid1, bus_a.rvalid0};
    assign a_busy[0] = bus_a.busy;         assign a_we[0] = bus_a.mem_we;
    assign a_rdata[0] = bus_a.rdata;       assign a_addr[0] = bus_a.mem_address;
    assign a_wdo[0] = bus_a.mem_data_out;
    assign a_gnt[1] = {bus_b.gnt1, bus_b.gnt0};
    assign a_rvalid[1] = {bus_b.rvalid1, bus_b.rvalid0};
    assign a_busy[1] = bus_b.busy;         assign a_we[1] = bus_b.mem_we;
    assign a_rdata[1] = bus_b.rdata;       assign a_addr[1] = bus_b.mem_address;
    assign a_wdo[1] = bus_b.mem_data_out;

    // Model: last transaction start cycle, its kind/owner, round-robin pointer.
    int            t_start [NDUT];
    logic          t_we    [NDUT];
    logic          t_own   [NDUT];
    logic          m_prio  [NDUT];
    logic [AW-1:0] m_addr  [NDUT];
    logic [DW-1:0] m_wdo   [NDUT];
    logic [DW-1:0] m_rdata [NDUT];
    int            cyc;
    int            checks;
    int            errors;
    logic          rand_en;

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int txn_len(input int d);
        return t_we[d] ? 1 : lat_of(d) + 2;
    endfunction

    function automatic logic m_busy(input int d);
        return (t_start[d] >= 0) && (cyc > t_start[d]) && (cyc <= t_start[d] + txn_len(d));
    endfunction

    function automatic logic [1:0] m_gnt(input int d);
        if (m_busy(d)) return 2'b00;
        case (d_req[d])
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return m_prio[d] ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic chk(input int d, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lat%0d cyc=%0d actual=%0h required=%0h",
                     name, lat_of(d), cyc, act, exp);
        end
    endtask

    task automatic post(input int d, input int r, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] w);
        s_pend[d][r]  = 1'b1;
        s_we[d][r]    = we;
        s_addr[d][r]  = a;
        s_wdata[d][r] = w;
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            t_start[d] = -1;
            t_we[d]    = 1'b0;
            t_own[d]   = 1'b0;
            m_prio[d]  = 1'b0;
            m_addr[d]  = '0;
            m_wdo[d]   = '0;
            m_rdata[d] = '0;
            s_pend[d]  = 2'b00;
            d_req[d]   = 2'b00;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < NDUT; d++) begin
            logic [1:0] g;
            int         r;
            g = m_gnt(d);
            if (t_start[d] >= 0 && !t_we[d] && cyc == t_start[d] + lat_of(d) + 1)
                m_rdata[d] = d_mdin[d];
            if (g != 2'b00) begin
                r            = g[1] ? 1 : 0;
                t_start[d]   = cyc;
                t_we[d]      = d_we[d][r];
                t_own[d]     = g[1];
                m_addr[d]    = d_addr[d][r];
                m_wdo[d]     = d_wdata[d][r];
                m_prio[d]    = !g[1];
                s_pend[d][r] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < NDUT; d++) begin
            logic [1:0] rv;
            rv = 2'b00;
            if (t_start[d] >= 0 && !t_we[d] && cyc == t_start[d] + lat_of(d) + 2)
                rv = t_own[d] ? 2'b10 : 2'b01;
            chk(d, "gnt", 32'(a_gnt[d]), 32'(m_gnt(d)));
            chk(d, "busy", 32'(a_busy[d]), 32'(m_busy(d)));
            chk(d, "mem_we", 32'(a_we[d]),
                32'(t_start[d] >= 0 && t_we[d] && cyc == t_start[d] + 1));
            chk(d, "rvalid", 32'(a_rvalid[d]), 32'(rv));
            chk(d, "rdata", a_rdata[d], m_rdata[d]);
            chk(d, "mem_address", a_addr[d], m_addr[d]);
            chk(d, "mem_data_out", a_wdo[d], m_wdo[d]);
        end
    endtask

    task automatic chk_all_zero(input string name);
        for (int d = 0; d < NDUT; d++) begin
            chk(d, {name, "_gnt"}, 32'(a_gnt[d]), 32'd0);
            chk(d, {name, "_rvalid"}, 32'(a_rvalid[d]), 32'd0);
            chk(d, {name, "_busy"}, 32'(a_busy[d]), 32'd0);
            chk(d, {name, "_mem_we"}, 32'(a_we[d]), 32'd0);
            chk(d, {name, "_rdata"}, a_rdata[d], 32'd0);
            chk(d, {name, "_mem_address"}, a_addr[d], 32'd0);
            chk(d, {name, "_mem_data_out"}, a_wdo[d], 32'd0);
        end
    endtask

    // Close the current cycle in the model, drive the next one, compare it.
    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            if (rand_en) begin
                for (int r = 0; r < 2; r++)
                    if (!s_pend[d][r] && $urandom_range(0, 2) == 0)
                        post(d, r, 1'($urandom_range(0, 1)), $urandom(), $urandom());
            end
            d_req[d] = s_pend[d];
            d_we[d]  = s_we[d];
            for (int r = 0; r < 2; r++) begin
                d_addr[d][r]  = s_addr[d][r];
                d_wdata[d][r] = s_wdata[d][r];
            end
            if (mdin_en[d]) begin
                d_mdin[d]  = mdin_dir[d];
                mdin_en[d] = 1'b0;
            end else begin
                d_mdin[d] = $urandom();
            end
        end
        #1;
        compare_all();
    endtask

    task automatic settle();
        int n;
        n = 0;
        while ((s_pend[0] != 0 || s_pend[1] != 0 || m_busy(0) || m_busy(1)) && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL settle_timeout cyc=%0d actual=%0d required=<50", cyc, n);
        end
    endtask

    logic [1:0] cont_exp [8];

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        rand_en = 1'b0;
        cont_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        for (int d = 0; d < NDUT; d++) begin
            mdin_en[d] = 1'b0;
            mdin_dir[d] = '0;
            d_we[d] = 2'b00;
            s_we[d] = 2'b00;
            d_mdin[d] = '0;
            for (int r = 0; r < 2; r++) begin
                d_addr[d][r] = '0;  d_wdata[d][r] = '0;
                s_addr[d][r] = '0;  s_wdata[d][r] = '0;
            end
        end
        resetn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_all_zero("por");
        resetn = 1'b1;
        #1;
        compare_all();

        // Contention: both requesters hold writes; prio starts at 0.
        for (int k = 0; k < 8; k++) begin
            for (int d = 0; d < NDUT; d++)
                for (int r = 0; r < 2; r++)
                    if (!s_pend[d][r]) post(d, r, 1'b1, $urandom(), $urandom());
            step();
            for (int d = 0; d < NDUT; d++) chk(d, "cont_gnt", 32'(a_gnt[d]), 32'(cont_exp[k]));
        end
        settle();

        // Single read on the latency-1 arbiter.
        post(0, 0, 1'b0, 32'h100, 32'h0);
        step();
        chk(0, "rd_gnt", 32'(a_gnt[0]), 32'h1);
        step();
        chk(0, "rd_addr", a_addr[0], 32'h100);
        chk(0, "rd_rvalid_t1", 32'(a_rvalid[0]), 32'h0);
        mdin_en[0] = 1'b1; mdin_dir[0] = 32'hDEADBEEF;
        step();
        chk(0, "rd_rvalid_t2", 32'(a_rvalid[0]), 32'h0);
        step();
        chk(0, "rd_rvalid_t3", 32'(a_rvalid[0]), 32'h1);
        chk(0, "rd_rdata_t3", a_rdata[0], 32'hDEADBEEF);
        step();
        chk(0, "rd_rvalid_t4", 32'(a_rvalid[0]), 32'h0);

        // Single write from requester 1 on both arbiters.
        for (int d = 0; d < NDUT; d++) post(d, 1, 1'b1, 32'h20, 32'h12345678);
        step();
        for (int d = 0; d < NDUT; d++) chk(d, "wr_gnt", 32'(a_gnt[d]), 32'h2);
        step();
        for (int d = 0; d < NDUT; d++) begin
            chk(d, "wr_mem_we", 32'(a_we[d]), 32'h1);
            chk(d, "wr_addr", a_addr[d], 32'h20);
            chk(d, "wr_data", a_wdo[d], 32'h12345678);
        end
        step();
        for (int d = 0; d < NDUT; d++) begin
            chk(d, "wr_busy_t2", 32'(a_busy[d]), 32'h0);
            chk(d, "wr_mem_we_t2", 32'(a_we[d]), 32'h0);
        end

        // Latency 3: data only sampled in the cycle 3 after the address.
        settle();
        post(1, 0, 1'b0, 32'h40, 32'h0);
        step();
        chk(1, "lat_gnt", 32'(a_gnt[1]), 32'h1);
        step();
        chk(1, "lat_addr", a_addr[1], 32'h40);
        mdin_en[1] = 1'b1; mdin_dir[1] = 32'h11111111;
        step();
        chk(1, "lat_busy_t2", 32'(a_busy[1]), 32'h1);
        mdin_en[1] = 1'b1; mdin_dir[1] = 32'h22222222;
        step();
        chk(1, "lat_rvalid_t3", 32'(a_rvalid[1]), 32'h0);
        mdin_en[1] = 1'b1; mdin_dir[1] = 32'hA5A5A5A5;
        step();
        chk(1, "lat_rvalid_t4", 32'(a_rvalid[1]), 32'h0);
        chk(1, "lat_busy_t4", 32'(a_busy[1]), 32'h1);
        mdin_en[1] = 1'b1; mdin_dir[1] = 32'h5A5A5A5A;
        step();
        chk(1, "lat_rvalid_t5", 32'(a_rvalid[1]), 32'h1);
        chk(1, "lat_rdata_t5", a_rdata[1], 32'hA5A5A5A5);
        step();
        chk(1, "lat_rvalid_t6", 32'(a_rvalid[1]), 32'h0);
        chk(1, "lat_rdata_hold", a_rdata[1], 32'hA5A5A5A5);
        chk(1, "lat_busy_t6", 32'(a_busy[1]), 32'h0);

        // Requests arriving while busy are ignored until IDLE.
        post(1, 0, 1'b0, 32'h80, 32'h0);
        step();
        chk(1, "ign_gnt0", 32'(a_gnt[1]), 32'h1);
        for (int k = 1; k <= 5; k++) begin
            if (k == 1) post(1, 1, 1'b1, 32'h84, 32'hCAFEF00D);
            step();
            chk(1, "ign_gnt_busy", 32'(a_gnt[1]), 32'h0);
        end
        step();
        chk(1, "ign_gnt1_after", 32'(a_gnt[1]), 32'h2);

        // Asynchronous reset in the middle of a read.
        settle();
        for (int d = 0; d < NDUT; d++) post(d, 0, 1'b0, 32'h200, 32'h0);
        step();
        step();
        step();
        for (int d = 0; d < NDUT; d++) chk(d, "mid_busy", 32'(a_busy[d]), 32'h1);
        #1;
        for (int d = 0; d < NDUT; d++) d_req[d] = 2'b11;
        resetn = 1'b0;
        #1;
        chk_all_zero("rst_async");
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk_all_zero("rst_hold");
        end
        @(negedge clk);
        model_reset();
        resetn = 1'b1;
        #1;
        compare_all();
        repeat (6) begin
            step();
            for (int d = 0; d < NDUT; d++) chk(d, "post_rst_rvalid", 32'(a_rvalid[d]), 32'h0);
        end

        // Randomized traffic against the model.
        rand_en = 1'b1;
        repeat (3000) step();
        rand_en = 1'b0;
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
